// File: rtl/decoder_pkg.sv
// Shared encodings for the registered one-hot decoder / scanner.
package decoder_pkg;

  // FSM state encodings; 2'd3 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Values of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_seq_onehot_dec.sv
// Combinational address to one-hot decoder with an enable gate.
module onehot_dec #(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   y
);

  // Set exactly one bit for the address when enabled, else all zero.
  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot decoder with a load-strobed DIRECT mode and
// an auto-SCAN mode that walks the outputs with a programmable dwell.
//
// Handshake: there is no valid/ready pair here; 'load' is a plain strobe
// sampled on the rising edge in DIRECT (and on the SCAN->DIRECT edge), and
// 'valid' simply flags that y is being driven.
module decoder_scan_seq
  import decoder_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**ADDR_W-1:0]  y,
  output logic [ADDR_W-1:0]     sel,
  output logic                  valid,
  output logic                  wrap,
  output logic [1:0]            state_dbg
);

  localparam logic [ADDR_W-1:0] SEL_MAX = {ADDR_W{1'b1}};

  state_t               state, next_state;
  logic [DWELL_W-1:0]   cnt, next_cnt;
  logic [ADDR_W-1:0]    next_sel;
  logic                 next_valid;
  logic                 next_wrap;
  logic [2**ADDR_W-1:0] next_y;

  assign state_dbg = state;

  // Next-state, next-sel and dwell counter decisions; en=0 overrides everything.
  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_cnt   = cnt;
    next_valid = 1'b0;
    next_wrap  = 1'b0;
    if (!en) begin
      next_state = ST_IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DIRECT: begin
          next_valid = 1'b1;
          next_cnt   = '0;
          if (mode == MODE_SCAN) begin
            next_state = ST_SCAN;
            next_sel   = '0;
          end else begin
            next_state = ST_DIRECT;
            if (load) next_sel = addr;
          end
        end
        ST_SCAN: begin
          next_valid = 1'b1;
          if (mode == MODE_DIRECT) begin
            // Leaving SCAN keeps the current sel unless a load arrives now.
            next_state = ST_DIRECT;
            next_cnt   = '0;
            if (load) next_sel = addr;
          end else if (cnt >= dwell) begin
            // >= so that a dwell lowered mid-hold takes effect immediately.
            next_cnt  = '0;
            next_sel  = sel + ADDR_W'(1);
            next_wrap = (sel == SEL_MAX);
          end else begin
            next_cnt = cnt + DWELL_W'(1);
          end
        end
        default: begin
          next_state = ST_IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Decode the next sel so y is registered alongside sel on the same edge.
  onehot_dec #(.ADDR_W(ADDR_W)) u_onehot_dec (
    .addr (next_sel),
    .en   (next_valid),
    .y    (next_y)
  );

  // FSM and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      cnt   <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= next_state;
      sel   <= next_sel;
      cnt   <= next_cnt;
      y     <= next_y;
      valid <= next_valid;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: a table of vectors on a 2-bit
// instance plus hand-written reset, hold and 3-bit scan sequences.
module tb_decoder_scan_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-bit address instance
  logic       en2, mode2, load2;
  logic [1:0] addr2;
  logic [3:0] dwell2;
  logic [3:0] y2;
  logic [1:0] sel2;
  logic       valid2, wrap2;
  logic [1:0] st2;

  // 3-bit address instance
  logic       en3, mode3, load3;
  logic [2:0] addr3;
  logic [3:0] dwell3;
  logic [7:0] y3;
  logic [2:0] sel3;
  logic       valid3, wrap3;
  logic [1:0] st3;

  decoder_scan_seq #(.ADDR_W(2), .DWELL_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .load(load2),
    .addr(addr2), .dwell(dwell2), .y(y2), .sel(sel2), .valid(valid2),
    .wrap(wrap2), .state_dbg(st2)
  );

  decoder_scan_seq #(.ADDR_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .load(load3),
    .addr(addr3), .dwell(dwell3), .y(y3), .sel(sel3), .valid(valid3),
    .wrap(wrap3), .state_dbg(st3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive2(input logic e, input logic m, input logic l,
                        input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    en2 = e; mode2 = m; load2 = l; addr2 = a; dwell2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic e, input logic m, input logic l,
                        input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    en3 = e; mode3 = m; load3 = l; addr3 = a; dwell3 = d;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       mode;
    logic       load;
    logic [1:0] addr;
    logic [3:0] dwell;
    logic [3:0] y;
    logic [1:0] sel;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t vecs[26];

  task automatic set_vec(input int i, input logic e, input logic m, input logic l,
                         input logic [1:0] a, input logic [3:0] d,
                         input logic [3:0] ey, input logic [1:0] es,
                         input logic ev, input logic ew);
    vecs[i].en = e;   vecs[i].mode = m;  vecs[i].load = l;
    vecs[i].addr = a; vecs[i].dwell = d;
    vecs[i].y = ey;   vecs[i].sel = es;  vecs[i].valid = ev; vecs[i].wrap = ew;
  endtask

  initial begin
    //            en mode load addr dwell   y      sel  v  w
    // DIRECT loads of every address, one cycle latency
    set_vec( 0, 1, 0, 1, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
    set_vec( 1, 1, 0, 1, 2'd1, 4'd0, 4'b0010, 2'd1, 1, 0);
    set_vec( 2, 1, 0, 1, 2'd2, 4'd0, 4'b0100, 2'd2, 1, 0);
    set_vec( 3, 1, 0, 1, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
    set_vec( 4, 1, 0, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    set_vec( 5, 1, 0, 1, 2'd2, 4'd0, 4'b0100, 2'd2, 1, 0);
    // drop en: outputs off, sel held; re-enable without load
    set_vec( 6, 0, 0, 0, 2'd0, 4'd0, 4'b0000, 2'd2, 0, 0);
    set_vec( 7, 0, 0, 1, 2'd1, 4'd0, 4'b0000, 2'd2, 0, 0);
    set_vec( 8, 1, 0, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    // SCAN dwell=0, wrap with the second 0001
    set_vec( 9, 1, 1, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
    set_vec(10, 1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    set_vec(11, 1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    set_vec(12, 1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    set_vec(13, 1, 1, 1, 2'd2, 4'd0, 4'b0001, 2'd0, 1, 1);
    set_vec(14, 1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    // back to DIRECT with no load: sel held at 1
    set_vec(15, 1, 0, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    // SCAN dwell=2: held 3 cycles, then live dwell drop to 0
    set_vec(16, 1, 1, 0, 2'd0, 4'd2, 4'b0001, 2'd0, 1, 0);
    set_vec(17, 1, 1, 0, 2'd0, 4'd2, 4'b0001, 2'd0, 1, 0);
    set_vec(18, 1, 1, 0, 2'd0, 4'd2, 4'b0001, 2'd0, 1, 0);
    set_vec(19, 1, 1, 0, 2'd0, 4'd2, 4'b0010, 2'd1, 1, 0);
    set_vec(20, 1, 1, 0, 2'd0, 4'd2, 4'b0010, 2'd1, 1, 0);
    set_vec(21, 1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    set_vec(22, 1, 1, 0, 2'd0, 4'd2, 4'b0100, 2'd2, 1, 0);
    // SCAN->DIRECT with load on the same edge honours the load
    set_vec(23, 1, 0, 1, 2'd3, 4'd2, 4'b1000, 2'd3, 1, 0);
    // DIRECT->SCAN restarts at 0, load ignored
    set_vec(24, 1, 1, 1, 2'd1, 4'd0, 4'b0001, 2'd0, 1, 0);
    // en=0 wins over mode
    set_vec(25, 0, 1, 0, 2'd0, 4'd0, 4'b0000, 2'd0, 0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] exp_y;
    en2 = 0; mode2 = 0; load2 = 0; addr2 = '0; dwell2 = '0;
    en3 = 0; mode3 = 0; load3 = 0; addr3 = '0; dwell3 = '0;

    // reset state
    #22;
    check("reset_y",     y2,     4'b0000);
    check("reset_sel",   sel2,   2'd0);
    check("reset_valid", valid2, 1'b0);
    check("reset_wrap",  wrap2,  1'b0);
    check("reset_state", st2,    2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 26; i++) begin
      drive2(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].addr, vecs[i].dwell);
      check($sformatf("vec%0d_y", i),     y2,     vecs[i].y);
      check($sformatf("vec%0d_sel", i),   sel2,   vecs[i].sel);
      check($sformatf("vec%0d_valid", i), valid2, vecs[i].valid);
      check($sformatf("vec%0d_wrap", i),  wrap2,  vecs[i].wrap);
    end

    // asynchronous reset mid-scan at sel=2
    drive2(1, 1, 0, 2'd0, 4'd0);
    drive2(1, 1, 0, 2'd0, 4'd0);
    drive2(1, 1, 0, 2'd0, 4'd0);
    check("prerst_sel", sel2, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_y",     y2,     4'b0000);
    check("async_rst_sel",   sel2,   2'd0);
    check("async_rst_valid", valid2, 1'b0);
    check("async_rst_state", st2,    2'd0);
    @(negedge clk);
    en2 = 0;
    rst_n = 1'b1;
    drive2(0, 1, 0, 2'd0, 4'd0);
    check("post_rst_idle_valid", valid2, 1'b0);
    check("post_rst_idle_state", st2,    2'd0);

    // SCAN to sel=2 then DIRECT: y must stay 0100 indefinitely
    drive2(1, 1, 0, 2'd0, 4'd0);
    check("rescan_y", y2, 4'b0001);
    drive2(1, 1, 0, 2'd0, 4'd0);
    drive2(1, 1, 0, 2'd0, 4'd0);
    check("scan_sel2_y", y2, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      drive2(1, 0, 0, 2'd1, 4'd0);
      check($sformatf("hold_direct%0d_y", i), y2, 4'b0100);
      check($sformatf("hold_direct%0d_state", i), st2, 2'd1);
    end

    // 3-bit instance: DIRECT load 5 -> 8'h20
    drive3(1, 0, 1, 3'd5, 4'd0);
    check("w3_direct_y",   y3,   8'h20);
    check("w3_direct_sel", sel3, 3'd5);

    // 3-bit SCAN dwell=0: walk of 8 outputs, wrap every 8 cycles
    for (int i = 0; i < 24; i++) exp_q.push_back(8'h01 << (i % 8));
    for (int i = 0; i < 24; i++) begin
      drive3(1, 1, 0, 3'd0, 4'd0);
      exp_y = exp_q.pop_front();
      check($sformatf("w3_scan%0d_y", i), y3, exp_y);
      check($sformatf("w3_scan%0d_wrap", i), wrap3, (i >= 8 && i % 8 == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
